// File: rtl/ifetch_unit.sv
// Multi-cycle instruction fetch unit: owns the PC, reads instruction memory
// over a one-outstanding req/ack handshake, holds the word in an instruction
// register and hands it to the decoder over valid/ready. The next PC is chosen
// by the decoder's npc_op, which is sampled on the accept edge.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   imem_req, imem_addr    read request strobe and word address (= pc)
//   imem_ack, imem_rdata   read response strobe and instruction word
//   instr_valid/ready      instruction handshake towards the decoder
//   npc_op                 next-PC select: 0/3 pc+4, 1 branch, 2 jump
//   instr, op, funct       instruction register and its opcode/funct fields
//   pc, pc_plus4           address of instr and its successor (link value)
//   fetch_cnt              instructions accepted since reset
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  npc_op,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned XW = 32;
    localparam logic [XW-1:0] PC_INIT  = {RESET_PC[XW-1:2], 2'b00};
    localparam logic [XW-1:0] PC4_INIT = PC_INIT + XW'(4);

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            ir_load;
    logic            pc_load;
    logic            accept;
    logic [XW-1:0]   pc_q;
    logic [XW-1:0]   pc4_q;
    logic [XW-1:0]   ir_q;
    logic [XW-1:0]   cnt_q;
    logic [XW-1:0]   br_off;
    logic [XW-1:0]   npc;

    assign accept = valid_q && instr_ready;

    // Next-PC selection from the held instruction; all sums wrap mod 2^32.
    always_comb begin
        br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        npc    = pc4_q;
        case (npc_op)
            NPC_SEQ:    npc = pc4_q;
            NPC_BRANCH: npc = pc4_q + br_off;
            NPC_JUMP:   npc = {pc4_q[31:28], ir_q[25:0], 2'b00};
            default:    npc = pc4_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control. The request is a registered pulse: the first
    // FETCH cycle after reset raises it, a FETCH entered on accept already
    // has it raised, and FETCH leaves for WAIT once it has been driven.
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        valid_d = valid_q;
        ir_load = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (req_q) begin
                    state_d = S_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ir_load = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= PC_INIT;
            pc4_q   <= PC4_INIT;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            req_q   <= req_d;
            valid_q <= valid_d;
            if (ir_load) begin
                ir_q <= imem_rdata;
            end
            if (pc_load) begin
                pc_q  <= npc;
                pc4_q <= npc + XW'(4);
                cnt_q <= cnt_q + XW'(1);
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = ir_q;
    assign op          = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc4_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Multi-cycle instruction fetch unit that feeds the opcode/function decoder and is steered by its next-PC selection. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. It presents the word to the decoder with a valid/ready handshake, then computes the next PC from the decoder's `npc_op`. It is the producer side of the decoder's `OP`/`Funct` inputs and the consumer of its `NPCOp` output.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset; bits [1:0] ignored (forced 0).
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `imem_req  out  1`: read request to instruction memory.
- `imem_addr  out  32`: word address of the read; equals `pc`.
- `imem_ack  in  1`: memory response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata  in  32`: returned instruction word.
- `instr_valid  out  1`: the instruction register holds an unconsumed instruction.
- `instr_ready  in  1`: the decoder/execute stage accepts the instruction this cycle.
- `npc_op  in  2`: next-PC selection, sampled only on accept. 0 selects PC+4, 1 selects branch, 2 selects jump, 3 is reserved and treated as PC+4.
- `instr  out  32`: the instruction register.
- `op  out  6`: `instr[31:26]`.
- `funct  out  6`: `instr[5:0]`.
- `pc  out  32`: address of the instruction in `instr`.
- `pc_plus4  out  32`: `pc + 4`, for the jal link value.
- `fetch_cnt  out  32`: number of instructions accepted since reset.

## Operation
- The FSM has three states: FETCH, WAIT, HOLD. The reset state is FETCH.
- **FETCH**
  - Drives `imem_req=1` for exactly one cycle with `imem_addr=pc`.
  - Transitions to WAIT.
- **WAIT**
  - `imem_req=0`.
  - On `imem_ack`, the IR captures `imem_rdata` and the FSM moves to HOLD. Otherwise it stays in WAIT; latency is unbounded.
- **HOLD**
  - `instr_valid=1`.
  - `instr`, `op`, `funct`, `pc` and `pc_plus4` stay stable until accept.
  - Accept is `instr_valid && instr_ready`. On accept:
    - the PC loads the next PC;
    - `fetch_cnt` increments;
    - the FSM moves to FETCH.
- **Next-PC computation**, combinational from the IR and the current PC:
  - npc_op 0 or 3: `pc + 4`.
  - npc_op 1: `pc + 4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - npc_op 2: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- **Arithmetic:** all 32-bit modulo 2^32. PC+4 from 32'hFFFF_FFFC wraps to 0. Branch offsets wrap the same way. `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.
- **Unexpected strobes:** `imem_ack` in FETCH or HOLD is ignored; the IR is unchanged. `instr_ready` outside HOLD is ignored.
- **Reset values:**
  - PC = `RESET_PC & ~3`
  - IR = 0, so `op`, `funct` and `instr` are 0
  - `instr_valid` = 0, `imem_req` = 0, `fetch_cnt` = 0
  - `pc_plus4` = PC + 4
- **Reset mid-operation**, in any state, including WAIT with a read outstanding:
  - all state returns to reset values immediately (asynchronously);
  - the outstanding read is abandoned; instruction memory shares `rst`, so no stale ack arrives;
  - fetching restarts at `RESET_PC`.

## Timing
- Reset deassert is seen at edge 0. Cycle 1 is FETCH: `imem_req=1`, `imem_addr=RESET_PC`.
- The earliest `imem_ack` is the cycle after the request. If ack is in cycle k, `instr_valid=1` from cycle k+1.
- If `instr_ready=1` in the first HOLD cycle, the next request is issued in the following cycle.
- Minimum period is 3 cycles per instruction: FETCH, WAIT with ack, HOLD with ready.
- `npc_op` is sampled only on the accept edge. Its value in any other cycle has no effect.
- `imem_req` is never high for two consecutive cycles. At most one read is outstanding.

## Test plan
- **Reset and first fetch.** Stimulus: `RESET_PC`=32'h0000_3000, assert then release `rst`. Required: `imem_req=1`, `imem_addr`=32'h3000 in cycle 1; `instr_valid`=0 and `fetch_cnt`=0 during reset.
- **Sequential fetch, ack latency 1 and 3.** Stimulus: return 32'h8C08_0004 (lw) at 32'h3000, `npc_op`=0, `instr_ready` tied high. Required: `op`=35, `pc`=32'h3000 in HOLD; next `imem_addr`=32'h3004; `fetch_cnt`=1.
- **Branch taken.** Stimulus: at `pc`=32'h3004, instr 32'h1000_FFFE (beq, offset -2), `npc_op`=1 on accept. Required: next `imem_addr`=32'h3000. With the same instr and `npc_op`=0: next address 32'h3008.
- **Jump.** Stimulus: at `pc`=32'h3008, instr 32'h0C00_0C10 (jal), `npc_op`=2. Required: `pc_plus4`=32'h300C in HOLD; next `imem_addr`=32'h0000_3040.
- **Backpressure and spurious strobes.** Stimulus: hold `instr_ready`=0 for 5 cycles; pulse `imem_ack` with 32'hDEAD_BEEF during HOLD; vary `npc_op` before accept. Required: `instr` and `pc` unchanged; only the `npc_op` present at accept steers the PC. Wrap check: `RESET_PC`=32'hFFFF_FFFC with `npc_op`=0 gives next `imem_addr`=0.
- **Reset in WAIT.** Stimulus: assert `rst` while a read is outstanding. Required: `instr_valid`=0 and `pc`=`RESET_PC` immediately; a fresh request to `RESET_PC` one cycle after release.
